wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin Wishbone B4 arbiter: lets N_MASTERS classic-cycle masters share one Wishbone slave port.
- Sits between master-side bus agents (cores, DMA) and a single downstream bus (wb_slave adapter or interconnect).
- Ownership is granted per cycle: a grant holds while the owning master keeps cyc asserted, which makes it burst-safe.
- Optional watchdog terminates hung transfers.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- TAGSIZE, 2, width of tga/tgc/tgd tags.
- TIMEOUT, 16, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  asynchronous active-low reset
- m_cyc_i  in  N_MASTERS  per-master cycle request
- m_stb_i  in  N_MASTERS  per-master strobe
- m_we_i  in  N_MASTERS  per-master write enable
- m_adr_i  in  N_MASTERS*32  packed addresses, master k at [32k+:32]
- m_dat_i  in  N_MASTERS*32  packed write data
- m_sel_i  in  N_MASTERS*4  packed byte selects
- m_tga_i / m_tgc_i / m_tgd_i  in  N_MASTERS*TAGSIZE  packed tags
- m_ack_o / m_err_o / m_rty_o  out  N_MASTERS  per-master terminations
- m_dat_o  out  32  read data broadcast (= s_dat_i)
- m_tgd_o  out  TAGSIZE  read tag broadcast (= s_tgd_i)
- s_cyc_o, s_stb_o, s_we_o  out  1  to slave
- s_adr_o, s_dat_o  out  32  to slave
- s_sel_o  out  4  to slave
- s_tga_o, s_tgc_o, s_tgd_o  out  TAGSIZE  to slave
- s_ack_i, s_err_i, s_rty_i  in  1  slave terminations
- s_dat_i  in  32  slave read data
- s_tgd_i  in  TAGSIZE  slave read tag
- gnt_o  out  N_MASTERS  one-hot current owner; all-zero when idle
- busy_o  out  1  bus owned

Behaviour:
- Registered state:
  - state: IDLE or GRANT.
  - gnt (one-hot).
  - last ($clog2(N_MASTERS) bits, index of the last granted master).
- Reset (rstn_i low, asynchronous):
  - state=IDLE, gnt=0, last=N_MASTERS-1, so master 0 wins first.
  - All outputs 0 while reset is held and in IDLE.
- Arbitration function: starting at index last+1 (wrapping modulo N_MASTERS), pick the first k with m_cyc_i[k]=1.
- IDLE:
  - Any m_cyc_i set at a clock edge -> GRANT; gnt=onehot(pick); last=pick.
  - Request at cycle t yields gnt_o and s_cyc_o at t+1, i.e. one cycle of arbitration latency.
- GRANT, owner g:
  - s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g].
  - s_we/adr/dat/sel/tga/tgc/tgd_o take master g's fields, combinationally.
  - m_ack_o[g]=s_ack_i, m_err_o[g]=s_err_i, m_rty_o[g]=s_rty_i; all other masters' terminations are 0.
- Release: an edge with m_cyc_i[g]=0 ends ownership.
  - If another master requests at that edge -> stay GRANT with the new pick (zero-bubble handoff).
  - Else -> IDLE.
  - The released master is lowest priority for the next pick.
- Non-owner requests are ignored: their terminations stay 0 and their fields are not forwarded. No preemption.
- Termination during release: s_ack_i asserted in a cycle where the owner already dropped cyc is dropped, because s_cyc_o=0.
- Simultaneous requests: rotation guarantees each requester waits at most N_MASTERS-1 grants.
- Reset mid-transfer: immediate abort, s_cyc_o/s_stb_o low asynchronously; the first grant after reset goes to master 0.
- busy_o = (state==GRANT).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter increments each cycle in GRANT with s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - The counter clears on any termination, on owner change and in IDLE.
  - When the counter == TIMEOUT-1: m_err_o[g]=1 for exactly that cycle, s_stb_o is forced 0 in that cycle, and the counter clears.
  - Ownership is retained until the master drops cyc.
- Undefined: no counter, no forced error; a hung slave holds the bus indefinitely.

Test Plan:
- Reset release, m_cyc_i=2'b01 held, slave acks each stb -> gnt_o=01 one cycle later; s_adr_o tracks m_adr_i[31:0]; m_ack_o=01 on acked cycles only.
- m_cyc_i=2'b11 asserted together from IDLE -> master 0 granted; after it drops cyc, gnt_o=10 on the next edge with no IDLE cycle; next contention goes to master 0.
- Master 1 does a 4-beat burst (cyc held, stb 4 cycles) while master 0 requests -> gnt_o stays 10 for all 4 acks; master 0 m_ack_o=0 throughout; handoff follows.
- rstn_i pulsed low mid-burst -> s_cyc_o=0 with no clock edge; after release with both requesting, gnt_o=01.
- s_err_i / s_rty_i pulse while master 1 owns -> m_err_o=10 / m_rty_o=10; m_dat_o equals s_dat_i=0xDEADBEEF on the ack cycle.
- WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> m_err_o[g]=1 on the 16th stalled cycle, single-cycle pulse; without the macro, no err after 100 cycles.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Wishbone B4 bundle between N_MASTERS classic-cycle masters and one shared slave port.
// The "slave" modport is the arbiter's view; "master" is the agents' view (masters plus downstream slave).
interface wb_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int TAGSIZE   = 2
);
  logic [N_MASTERS-1:0]         m_cyc_i, m_stb_i, m_we_i;
  logic [N_MASTERS*32-1:0]      m_adr_i, m_dat_i;
  logic [N_MASTERS*4-1:0]       m_sel_i;
  logic [N_MASTERS*TAGSIZE-1:0] m_tga_i, m_tgc_i, m_tgd_i;
  logic [N_MASTERS-1:0]         m_ack_o, m_err_o, m_rty_o;
  logic [31:0]                  m_dat_o;
  logic [TAGSIZE-1:0]           m_tgd_o;

  logic                         s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]                  s_adr_o, s_dat_o;
  logic [3:0]                   s_sel_o;
  logic [TAGSIZE-1:0]           s_tga_o, s_tgc_o, s_tgd_o;
  logic                         s_ack_i, s_err_i, s_rty_i;
  logic [31:0]                  s_dat_i;
  logic [TAGSIZE-1:0]           s_tgd_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_tga_i, m_tgc_i, m_tgd_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o, m_tgd_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_tga_o, s_tgc_o, s_tgd_o,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i, s_tgd_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_tga_i, m_tgc_i, m_tgd_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o, m_tgd_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_tga_o, s_tgc_o, s_tgd_o,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i, s_tgd_i
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: ownership held while the granted master keeps cyc asserted.
// Optional watchdog (macro WB_ARB_TIMEOUT_EN) errors out transfers stalled for TIMEOUT cycles.
module wb_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int TAGSIZE   = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  wb_arbiter_if.slave          bus,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic                 busy_o
);
  localparam int IDX_W = $clog2(N_MASTERS);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [N_MASTERS-1:0] gnt, gnt_nxt;
  logic [IDX_W-1:0]     last, last_nxt, pick, owner;
  logic                 pick_vld, owner_cyc, busy, term_en, tmo_hit;

  // Search starts just after the last owner, so the released master ranks lowest.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last) + i) % N_MASTERS;
      if (!pick_vld && bus.m_cyc_i[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int k = 0; k < N_MASTERS; k++)
      if (gnt[k]) owner = IDX_W'(k);
  end

  assign busy      = (state == GRANT);
  assign owner_cyc = bus.m_cyc_i[owner];
  assign term_en   = busy & owner_cyc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IDX_W'(N_MASTERS - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick;
          last_nxt  = pick;
        end
      end
      GRANT: begin
        // Handoff happens on the same edge the owner drops cyc, without an idle bubble.
        if (!owner_cyc) begin
          if (pick_vld) begin
            gnt_nxt  = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick;
            last_nxt = pick;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    int o;
    o           = int'(owner);
    bus.s_cyc_o = term_en;
    bus.s_stb_o = term_en & bus.m_stb_i[owner] & ~tmo_hit;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_tga_o = '0;
    bus.s_tgc_o = '0;
    bus.s_tgd_o = '0;
    if (busy) begin
      bus.s_we_o  = bus.m_we_i[owner];
      bus.s_adr_o = bus.m_adr_i[32*o +: 32];
      bus.s_dat_o = bus.m_dat_i[32*o +: 32];
      bus.s_sel_o = bus.m_sel_i[4*o +: 4];
      bus.s_tga_o = bus.m_tga_i[TAGSIZE*o +: TAGSIZE];
      bus.s_tgc_o = bus.m_tgc_i[TAGSIZE*o +: TAGSIZE];
      bus.s_tgd_o = bus.m_tgd_i[TAGSIZE*o +: TAGSIZE];
    end
    // Terminations arriving after the owner dropped cyc are discarded.
    bus.m_ack_o = gnt & {N_MASTERS{bus.s_ack_i & term_en}};
    bus.m_err_o = gnt & {N_MASTERS{(bus.s_err_i & term_en) | tmo_hit}};
    bus.m_rty_o = gnt & {N_MASTERS{bus.s_rty_i & term_en}};
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_tgd_o = bus.s_tgd_i;
  assign gnt_o       = gnt;
  assign busy_o      = busy;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             any_term;

  assign any_term = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  // Hit depends only on the counter so a slave acking combinationally from stb cannot loop.
  assign tmo_hit  = term_en && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      tmo_cnt <= '0;
    else if (!busy || any_term || tmo_hit || (gnt_nxt != gnt))
      tmo_cnt <= '0;
    else if (term_en && bus.m_stb_i[owner])
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table with a scoreboard queue, plus
// hand-written sequences for async reset and the watchdog (WB_ARB_TIMEOUT_EN).
module tb_wb_arbiter;
  localparam int NM = 2;
  localparam int TS = 2;

  localparam logic [31:0]   ADR [2] = '{32'h1000_0040, 32'h2000_0080};
  localparam logic [31:0]   DAT [2] = '{32'hA5A5_0001, 32'h5A5A_0002};
  localparam logic [3:0]    SEL [2] = '{4'h3, 4'hC};
  localparam logic          WE  [2] = '{1'b0, 1'b1};
  localparam logic [TS-1:0] TGA [2] = '{2'd1, 2'd2};
  localparam logic [TS-1:0] TGC [2] = '{2'd2, 2'd1};
  localparam logic [TS-1:0] TGD [2] = '{2'd3, 2'd0};
  localparam logic [31:0]   SDAT = 32'hDEAD_BEEF;
  localparam logic [TS-1:0] STGD = 2'd1;

  logic clk, rstn;
  logic [NM-1:0] gnt;
  logic busy;
  int n_pass, n_total;

  wb_arbiter_if #(.N_MASTERS(NM), .TAGSIZE(TS)) bus ();

  wb_arbiter #(.N_MASTERS(NM), .TAGSIZE(TS), .TIMEOUT(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus), .gnt_o(gnt), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cyc, stb;
    logic       ack, err, rty;
    int         own;
    logic       scyc, sstb;
    logic [1:0] mack, merr, mrty;
  } vec_t;

  typedef struct {
    logic [10:0]  ctrl;
    logic [108:0] data;
  } exp_t;

  vec_t vecs [22];
  exp_t sb [$];

  function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic ack, logic err, logic rty,
                              int own, logic scyc, logic sstb,
                              logic [1:0] mack, logic [1:0] merr, logic [1:0] mrty);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.rty = rty; v.own = own;
    v.scyc = scyc; v.sstb = sstb; v.mack = mack; v.merr = merr; v.mrty = mrty;
    return v;
  endfunction

  function automatic logic [10:0] exp_ctrl(vec_t v);
    logic [1:0] g;
    g = (v.own < 0) ? 2'b00 : (2'b01 << v.own);
    return {g, (v.own >= 0), v.scyc, v.sstb, v.mack, v.merr, v.mrty};
  endfunction

  function automatic logic [108:0] exp_data(int own);
    if (own < 0) return {75'd0, SDAT, STGD};
    return {ADR[own], DAT[own], SEL[own], WE[own], TGA[own], TGC[own], TGD[own], SDAT, STGD};
  endfunction

  function automatic logic [10:0] act_ctrl();
    return {gnt, busy, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_rty_o};
  endfunction

  function automatic logic [108:0] act_data();
    return {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_tga_o, bus.s_tgc_o,
            bus.s_tgd_o, bus.m_dat_o, bus.m_tgd_o};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err, input logic rty);
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.s_ack_i = ack;
    bus.s_err_i = err;
    bus.s_rty_i = rty;
  endtask

  initial begin
    exp_t e;
    int first_err, n_err, n_err_other;
    logic stb_at_err;

    n_pass = 0;
    n_total = 0;
    rstn = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    bus.m_we_i  = {WE[1], WE[0]};
    bus.m_adr_i = {ADR[1], ADR[0]};
    bus.m_dat_i = {DAT[1], DAT[0]};
    bus.m_sel_i = {SEL[1], SEL[0]};
    bus.m_tga_i = {TGA[1], TGA[0]};
    bus.m_tgc_i = {TGC[1], TGC[0]};
    bus.m_tgd_i = {TGD[1], TGD[0]};
    bus.s_dat_i = SDAT;
    bus.s_tgd_i = STGD;

    //                cyc    stb    ack  err  rty  own scyc sstb mack   merr   mrty
    vecs[0]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[1]  = mk(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[2]  = mk(2'b11, 2'b11, 1'b1, 1'b0, 1'b0,  0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
    vecs[3]  = mk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[4]  = mk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[5]  = mk(2'b11, 2'b10, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
    vecs[6]  = mk(2'b01, 2'b01, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[7]  = mk(2'b01, 2'b01, 1'b1, 1'b0, 1'b0,  0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
    vecs[8]  = mk(2'b11, 2'b11, 1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
    vecs[9]  = mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[10] = mk(2'b11, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[11] = mk(2'b11, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[12] = mk(2'b11, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[13] = mk(2'b11, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[14] = mk(2'b11, 2'b10, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00);
    vecs[15] = mk(2'b11, 2'b10, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10);
    vecs[16] = mk(2'b01, 2'b01, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[17] = mk(2'b01, 2'b01, 1'b1, 1'b0, 1'b0,  0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
    vecs[18] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[19] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[20] = mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    vecs[21] = mk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 128'(act_ctrl()), 128'(11'd0));
    check("reset_data", 128'(act_data()), 128'(exp_data(-1)));
    #2 rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].err, vecs[i].rty);
      sb.push_back('{exp_ctrl(vecs[i]), exp_data(vecs[i].own)});
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("vec%0d_sb_empty", i), 128'(0), 128'(1));
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_ctrl", i), 128'(act_ctrl()), 128'(e.ctrl));
        check($sformatf("vec%0d_data", i), 128'(act_data()), 128'(e.data));
      end
      @(posedge clk);
      #1;
    end

    // Master 1 owns mid-transfer; reset must abort without a clock edge.
    drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    #1;
    check("pre_rst_owner", 128'({gnt, bus.s_cyc_o, bus.s_stb_o}), 128'({2'b10, 1'b1, 1'b1}));
    #1 rstn = 1'b0;
    #1;
    check("async_rst_ctrl", 128'(act_ctrl()), 128'(11'd0));
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    check("rst_release_idle", 128'({gnt, busy}), 128'(3'b000));
    @(posedge clk);
    #1;
    check("first_gnt_after_rst", 128'({gnt, bus.s_cyc_o}), 128'({2'b01, 1'b1}));

    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("idle_before_stall", 128'({gnt, busy}), 128'(3'b000));
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("stall_grant", 128'(gnt), 128'(2'b01));

    first_err = 0;
    n_err = 0;
    n_err_other = 0;
    stb_at_err = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m_err_o[1]) n_err_other++;
      if (bus.m_err_o[0]) begin
        n_err++;
        if (first_err == 0) begin
          first_err = i;
          stb_at_err = bus.s_stb_o;
        end
      end
    end
    check("tmo_first_err_cycle", 128'(first_err), 128'(16));
    check("tmo_single_pulse", 128'(n_err), 128'(1));
    check("tmo_stb_forced_low", 128'(stb_at_err), 128'(1'b0));
    check("tmo_other_err", 128'(n_err_other), 128'(0));
`else
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.m_err_o != 2'b00) n_err++;
    end
    check("no_tmo_err", 128'(n_err), 128'(0));
`endif
    check("stall_owner_kept", 128'({gnt, bus.s_cyc_o}), 128'({2'b01, 1'b1}));

    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("final_idle", 128'({gnt, busy}), 128'(3'b000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
